// File: rtl/data_memory_controller.sv
// data_memory_controller: initiator side of the data_memory port.
// Takes one load/store request at a time over a valid/ready handshake, drives
// signal_memread/signal_memwrite/address/data_to_write toward data_memory,
// captures its registered data_out and returns a one-cycle response pulse.
// A saturating counter tracks completed accesses.
// Optional feature: define LSU_RMW_EN to enable read-modify-write add requests
// (req_rmw=1 with req_write=0). Without it req_rmw is ignored and no adder exists.
module data_memory_controller #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clock,
    input  logic              clear,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic              req_rmw,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              signal_memread,
    output logic              signal_memwrite,
    output logic [ADDR_W-1:0] address,
    output logic [DATA_W-1:0] data_to_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  access_count
);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        RD_ISSUE = 3'd1,
        RD_WAIT  = 3'd2,
        WR_ISSUE = 3'd3,
        DONE     = 3'd4
    } state_t;

    state_t state;
    state_t next_state;

    // Request fields held for the duration of the access
    logic [ADDR_W-1:0] addr_p0;
    logic [DATA_W-1:0] wdata_p0;
    logic              rmw_p0;

    logic accept;
    logic rmw_req;

    // Next values of the registered outputs
    logic              req_ready_d;
    logic              resp_valid_d;
    logic [DATA_W-1:0] resp_rdata_d;
    logic              memread_d;
    logic              memwrite_d;
    logic [ADDR_W-1:0] address_d;
    logic [DATA_W-1:0] data_to_write_d;
    logic [CNT_W-1:0]  access_count_d;

    // Access counter sticks at all-ones instead of wrapping
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
        if (cnt == {CNT_W{1'b1}})
            sat_inc = cnt;
        else
            sat_inc = cnt + 1'b1;
    endfunction

`ifdef LSU_RMW_EN
    // RMW sum wraps modulo 2**DATA_W; the carry out is dropped
    function automatic logic [DATA_W-1:0] wrap_add(input logic [DATA_W-1:0] a,
                                                   input logic [DATA_W-1:0] b);
        wrap_add = a + b;
    endfunction

    // A store always wins over the RMW flag
    assign rmw_req = req_rmw && !req_write;
`else
    logic unused_rmw;
    assign unused_rmw = req_rmw;
    assign rmw_req    = 1'b0;
`endif

    assign accept = req_valid && req_ready;

    // State register and per-access control flag
    always_ff @(posedge clock) begin
        if (clear) begin
            state  <= IDLE;
            rmw_p0 <= 1'b0;
        end else begin
            state <= next_state;
            if (accept)
                rmw_p0 <= rmw_req;
        end
    end

    // Request operands are only sampled at the accept edge
    always_ff @(posedge clock) begin
        if (accept) begin
            addr_p0  <= req_addr;
            wdata_p0 <= req_wdata;
        end
    end

    // Next-state sequencing of the access
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (accept)
                    next_state = req_write ? WR_ISSUE : RD_ISSUE;
            end
            RD_ISSUE: next_state = RD_WAIT;
            RD_WAIT:  next_state = rmw_p0 ? WR_ISSUE : DONE;
            WR_ISSUE: next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Output decode from the upcoming state so every output is a flop
    always_comb begin
        req_ready_d     = (next_state == IDLE);
        resp_valid_d    = (next_state == DONE);
        memread_d       = (next_state == RD_ISSUE);
        memwrite_d      = (next_state == WR_ISSUE);
        address_d       = '0;
        data_to_write_d = '0;
        resp_rdata_d    = resp_rdata;
        access_count_d  = access_count;

        // Entering an issue state straight from IDLE: operands are still on the request bus
        if (memread_d || memwrite_d)
            address_d = (state == IDLE) ? req_addr : addr_p0;

        if (memwrite_d) begin
            if (state == IDLE)
                data_to_write_d = req_wdata;
            else
`ifdef LSU_RMW_EN
                data_to_write_d = wrap_add(mem_rdata, wdata_p0);
`else
                data_to_write_d = wdata_p0;
`endif
        end

        // data_memory's registered data_out is valid during RD_WAIT
        if (state == RD_WAIT)
            resp_rdata_d = mem_rdata;

        if (resp_valid_d)
            access_count_d = sat_inc(access_count);
    end

    // Output registers
    always_ff @(posedge clock) begin
        if (clear) begin
            req_ready       <= 1'b1;
            resp_valid      <= 1'b0;
            resp_rdata      <= '0;
            signal_memread  <= 1'b0;
            signal_memwrite <= 1'b0;
            address         <= '0;
            data_to_write   <= '0;
            access_count    <= '0;
        end else begin
            req_ready       <= req_ready_d;
            resp_valid      <= resp_valid_d;
            resp_rdata      <= resp_rdata_d;
            signal_memread  <= memread_d;
            signal_memwrite <= memwrite_d;
            address         <= address_d;
            data_to_write   <= data_to_write_d;
            access_count    <= access_count_d;
        end
    end

endmodule

// File: tb/tb_data_memory_controller.sv
// Directed bench for data_memory_controller with a behavioural data_memory
// (registered data_out, init table restored on clear).
module tb_data_memory_controller;

    logic        clock;
    logic        clear;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic        req_rmw;
    logic [4:0]  req_addr;
    logic [7:0]  req_wdata;
    logic        resp_valid;
    logic [7:0]  resp_rdata;
    logic        signal_memread;
    logic        signal_memwrite;
    logic [4:0]  address;
    logic [7:0]  data_to_write;
    logic [7:0]  mem_rdata;
    logic [15:0] access_count;

    int vec_count = 0;
    int err_count = 0;
    int wr_cycles = 0;
    int rd_cycles = 0;
    int resp_cnt  = 0;
    logic both_seen = 1'b0;

    logic [7:0] mem [32];

    data_memory_controller #(.ADDR_W(5), .DATA_W(8), .CNT_W(16)) dut (
        .clock(clock), .clear(clear),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_rmw(req_rmw),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .signal_memread(signal_memread), .signal_memwrite(signal_memwrite),
        .address(address), .data_to_write(data_to_write),
        .mem_rdata(mem_rdata), .access_count(access_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic logic [7:0] init_val(input int i);
        if (i == 17) return 8'hFF;
        if (i == 31) return 8'hF1;
        return 8'(i);
    endfunction

    // Behavioural data_memory
    always @(posedge clock) begin
        if (clear) begin
            for (int i = 0; i < 32; i++) mem[i] <= init_val(i);
            mem_rdata <= 8'h00;
        end else begin
            if (signal_memread)  mem_rdata <= mem[address];
            if (signal_memwrite) mem[address] <= data_to_write;
        end
    end

    // Activity monitor
    always @(negedge clock) begin
        if (signal_memread && signal_memwrite) both_seen = 1'b1;
        if (signal_memwrite) wr_cycles++;
        if (signal_memread)  rd_cycles++;
        if (resp_valid)      resp_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic do_req(input logic w, input logic rmw, input logic [4:0] a,
                          input logic [7:0] d, output int lat);
        int guard = 0;
        while (!req_ready && guard < 20) begin
            tick();
            guard++;
        end
        if (guard >= 20) check("ready_wait", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = w;
        req_rmw   = rmw;
        req_addr  = a;
        req_wdata = d;
        tick();
        req_valid = 1'b0;
        req_write = 1'b0;
        req_rmw   = 1'b0;
        lat = 1;
        while (!resp_valid && lat < 12) begin
            tick();
            lat++;
        end
    endtask

    initial begin
        int lat;
        int c0, rd0, wr0, r0;

        clear = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_rmw = 1'b0;
        req_addr = '0; req_wdata = '0;
        tick(); tick();

        // Reset state
        check("rst_ready",   32'(req_ready), 32'd1);
        check("rst_resp",    32'(resp_valid), 32'd0);
        check("rst_rdata",   32'(resp_rdata), 32'h00);
        check("rst_memrd",   32'(signal_memread), 32'd0);
        check("rst_memwr",   32'(signal_memwrite), 32'd0);
        check("rst_count",   32'(access_count), 32'd0);
        clear = 1'b0;
        tick();

        // 1: load addr 17
        do_req(1'b0, 1'b0, 5'd17, 8'h00, lat);
        check("t1_lat",   32'(lat), 32'd3);
        check("t1_rdata", 32'(resp_rdata), 32'hFF);
        check("t1_count", 32'(access_count), 32'd1);

        // 2: store addr 5 then load it back
        wr0 = wr_cycles;
        do_req(1'b1, 1'b0, 5'd5, 8'hA5, lat);
        check("t2_st_lat",   32'(lat), 32'd2);
        check("t2_rd_held",  32'(resp_rdata), 32'hFF);
        check("t2_count",    32'(access_count), 32'd2);
        tick();
        check("t2_wr_once",  32'(wr_cycles - wr0), 32'd1);
        do_req(1'b0, 1'b0, 5'd5, 8'h00, lat);
        check("t2_ld_rdata", 32'(resp_rdata), 32'hA5);

        // 3: request held through busy cycles with changing fields
        tick();
        c0 = int'(access_count); rd0 = rd_cycles; wr0 = wr_cycles;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd17; req_wdata = 8'h00;
        tick();
        req_write = 1'b1; req_addr = 5'd5; req_wdata = 8'h77;
        tick(); tick();
        check("t3_resp",  32'(resp_valid), 32'd1);
        check("t3_rdata", 32'(resp_rdata), 32'hFF);
        req_valid = 1'b0; req_write = 1'b0;
        tick(); tick();
        check("t3_count", 32'(access_count), 32'(c0 + 1));
        check("t3_rd",    32'(rd_cycles - rd0), 32'd1);
        check("t3_wr",    32'(wr_cycles - wr0), 32'd0);
        do_req(1'b0, 1'b0, 5'd5, 8'h00, lat);
        check("t3_mem5",  32'(resp_rdata), 32'hA5);

        // store with rmw flag set is a plain store
        do_req(1'b1, 1'b1, 5'd6, 8'h3C, lat);
        check("st_rmw_lat", 32'(lat), 32'd2);
        do_req(1'b0, 1'b0, 5'd6, 8'h00, lat);
        check("st_rmw_rd",  32'(resp_rdata), 32'h3C);

`ifdef LSU_RMW_EN
        // 4: RMW addr 31 + 0x20 wraps
        tick();
        rd0 = rd_cycles; wr0 = wr_cycles;
        do_req(1'b0, 1'b1, 5'd31, 8'h20, lat);
        check("t4_lat",   32'(lat), 32'd4);
        check("t4_rdata", 32'(resp_rdata), 32'hF1);
        check("t4_rd",    32'(rd_cycles - rd0), 32'd1);
        check("t4_wr",    32'(wr_cycles - wr0), 32'd1);
        do_req(1'b0, 1'b0, 5'd31, 8'h00, lat);
        check("t4_reload", 32'(resp_rdata), 32'h11);
`else
        // 6: rmw flag ignored, plain load
        tick();
        wr0 = wr_cycles;
        do_req(1'b0, 1'b1, 5'd2, 8'h20, lat);
        check("t6_lat",    32'(lat), 32'd3);
        check("t6_rdata",  32'(resp_rdata), 32'h02);
        check("t6_nowr",   32'(wr_cycles - wr0), 32'd0);
        do_req(1'b0, 1'b0, 5'd2, 8'h00, lat);
        check("t6_reload", 32'(resp_rdata), 32'h02);
`endif

        // 5: clear during RD_WAIT aborts the access
        tick();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 5'd9;
        tick();
        req_valid = 1'b0;
        tick();
        clear = 1'b1;
        tick();
        check("t5_ready",  32'(req_ready), 32'd1);
        check("t5_resp",   32'(resp_valid), 32'd0);
        check("t5_rdata",  32'(resp_rdata), 32'h00);
        check("t5_memrd",  32'(signal_memread), 32'd0);
        check("t5_memwr",  32'(signal_memwrite), 32'd0);
        check("t5_addr",   32'(address), 32'd0);
        check("t5_wdata",  32'(data_to_write), 32'd0);
        check("t5_count",  32'(access_count), 32'd0);
        clear = 1'b0;
        r0 = resp_cnt;
        tick(); tick(); tick(); tick();
        check("t5_noresp", 32'(resp_cnt - r0), 32'd0);
        do_req(1'b0, 1'b0, 5'd3, 8'h00, lat);
        check("t5_ld3",    32'(resp_rdata), 32'h03);
        do_req(1'b0, 1'b0, 5'd5, 8'h00, lat);
        check("t5_ld5",    32'(resp_rdata), 32'h05);
        check("t5_count2", 32'(access_count), 32'd2);

        tick();
        check("excl_rw", 32'(both_seen), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
